// File: rtl/fifo_wr_arb_pkg.sv
// fifo_wr_arb_pkg: shared state encoding and stats counter width for the FIFO write arbiter
package fifo_wr_arb_pkg;
    typedef enum logic {IDLE, BURST} state_t;
    localparam int STAT_W = 16;
endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick: combinational rotate-priority selector, first valid index at or after ptr_i
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  valid_i,
    input  logic [IW-1:0] ptr_i,
    output logic          found_o,
    output logic [IW-1:0] idx_o
);
    logic [IW-1:0] j;
    // Scan offsets from farthest to nearest so the nearest valid wins
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        j       = '0;
        for (int k = N - 1; k >= 0; k--) begin
            j = IW'((int'(ptr_i) + k) % N);
            if (valid_i[j]) begin
                found_o = 1'b1;
                idx_o   = j;
            end
        end
    end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter for one async FIFO write port.
// Optional per-requester beat statistics via FIFO_WR_ARB_STATS_EN.
module fifo_wr_arbiter
    import fifo_wr_arb_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int DSIZE    = 8,
    parameter int MAXBEATS = 16
) (
    input  logic                     wclk,
    input  logic                     wrst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*DSIZE-1:0]    req_data,
    input  logic [NREQ-1:0]          req_last,
    output logic [NREQ-1:0]          req_ready,
    output logic                     winc,
    output logic [DSIZE-1:0]         wdata,
    input  logic                     wfull,
    output logic [$clog2(NREQ)-1:0]  grant_id,
    output logic                     busy,
`ifdef FIFO_WR_ARB_STATS_EN
    output logic [NREQ*STAT_W-1:0]   beat_cnt,
`endif
    output logic                     burst_err
);
    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(MAXBEATS + 1);

    state_t                       state_q;
    logic [IW-1:0]                grant_q, rr_ptr_q, rr_ptr_d, pick;
    logic [CW-1:0]                cnt_q;
    logic                         err_q, found, accept, is_last, cap, rel;
    logic [NREQ-1:0][DSIZE-1:0]   data_a;

    rr_pick #(.N(NREQ), .IW(IW)) u_pick (
        .valid_i (req_valid),
        .ptr_i   (rr_ptr_q),
        .found_o (found),
        .idx_o   (pick)
    );

    assign data_a    = req_data;
    assign accept    = (state_q == BURST) && req_valid[grant_q] && !wfull;
    assign is_last   = req_last[grant_q];
    assign cap       = accept && !is_last && (cnt_q == CW'(MAXBEATS - 1));
    assign rel       = (accept && is_last) || cap;
    assign rr_ptr_d  = (grant_q == IW'(NREQ - 1)) ? '0 : grant_q + 1'b1;
    assign req_ready = accept ? NREQ'(1) << grant_q : '0;
    assign winc      = accept;
    assign wdata     = (state_q == BURST) ? data_a[grant_q] : '0;
    assign grant_id  = grant_q;
    assign busy      = (state_q == BURST);
    assign burst_err = err_q;

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            err_q <= cap;
            if (state_q == IDLE) begin
                if (found) begin
                    state_q <= BURST;
                    grant_q <= pick;
                end
            end else if (rel) begin
                state_q  <= IDLE;
                cnt_q    <= '0;
                rr_ptr_q <= rr_ptr_d;
            end else if (accept) begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

`ifdef FIFO_WR_ARB_STATS_EN
    logic [NREQ-1:0][STAT_W-1:0] stat_q;
    assign beat_cnt = stat_q;
    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            stat_q <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++)
                if (accept && grant_q == IW'(i) && stat_q[i] != '1)
                    stat_q[i] <= stat_q[i] + STAT_W'(1);
        end
    end
`endif
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: randomized scoreboard bench for fifo_wr_arbiter against a burst-level reference model
module tb_fifo_wr_arbiter;
    localparam int NREQ = 4, DSIZE = 8, MAXB = 16, IW = 2;

    logic                  wclk = 1'b0, wrst, winc, wfull, busy, burst_err;
    logic [NREQ-1:0]       req_valid, req_last, req_ready;
    logic [NREQ*DSIZE-1:0] req_data;
    logic [DSIZE-1:0]      wdata;
    logic [IW-1:0]         grant_id;
`ifdef FIFO_WR_ARB_STATS_EN
    logic [NREQ*16-1:0]    beat_cnt;
`endif

    fifo_wr_arbiter #(.NREQ(NREQ), .DSIZE(DSIZE), .MAXBEATS(MAXB)) dut (
        .wclk      (wclk),
        .wrst      (wrst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .winc      (winc),
        .wdata     (wdata),
        .wfull     (wfull),
        .grant_id  (grant_id),
        .busy      (busy),
`ifdef FIFO_WR_ARB_STATS_EN
        .beat_cnt  (beat_cnt),
`endif
        .burst_err (burst_err)
    );

    always #5 wclk = ~wclk;

    typedef struct packed {
        logic            busy;
        logic            err;
        logic [NREQ-1:0] rdy;
        logic [IW-1:0]   gid;
    } st_t;

    st_t                   sq[$];
    logic [IW+DSIZE-1:0]   bq[$];
    int                    n_cmp = 0, n_bad = 0;
    bit                    m_busy, m_err;
    int                    m_own, m_ptr, m_cnt;
    int                    m_stat[NREQ];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: owner, pointer and beat count of the current burst, evaluated once per cycle
    always @(negedge wclk) begin
        st_t e;
        bit  acc, fnd;
        if (wrst) begin
            m_busy = 0; m_err = 0; m_own = 0; m_ptr = 0; m_cnt = 0;
            foreach (m_stat[i]) m_stat[i] = 0;
            sq.push_back('0);
        end else begin
            acc    = m_busy && req_valid[m_own] && !wfull;
            e.busy = m_busy;
            e.err  = m_err;
            e.gid  = IW'(m_own);
            e.rdy  = acc ? NREQ'(1) << m_own : '0;
            sq.push_back(e);
            m_err = 0;
            if (!m_busy) begin
                fnd = 0;
                for (int k = 0; k < NREQ; k++)
                    if (!fnd && req_valid[(m_ptr + k) % NREQ]) begin
                        fnd = 1;
                        m_own = (m_ptr + k) % NREQ;
                    end
                m_busy = fnd;
            end else if (acc) begin
                bq.push_back({IW'(m_own), req_data[m_own*DSIZE +: DSIZE]});
                m_cnt++;
                if (m_stat[m_own] < 65535) m_stat[m_own]++;
                if (req_last[m_own] || m_cnt == MAXB) begin
                    m_err  = !req_last[m_own];
                    m_busy = 0;
                    m_cnt  = 0;
                    m_ptr  = (m_own + 1) % NREQ;
                end
            end
        end
    end

    // Monitor: compares per-cycle status and every FIFO write against the queues
    always @(negedge wclk) begin
        st_t                 e;
        logic [IW+DSIZE-1:0] b;
        #1;
        if (sq.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL status_queue at %0t: got empty expected entry", $time);
        end else begin
            e = sq.pop_front();
            chk("busy", int'(busy), int'(e.busy));
            chk("burst_err", int'(burst_err), int'(e.err));
            chk("req_ready", int'(req_ready), int'(e.rdy));
            chk("winc", int'(winc), int'(|e.rdy));
            chk("grant_id", int'(grant_id), int'(e.gid));
            if (winc) begin
                if (bq.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL beat_queue at %0t: got write %0h expected none", $time, wdata);
                end else begin
                    b = bq.pop_front();
                    chk("write", int'({grant_id, wdata}), int'(b));
                end
            end
        end
    end

    initial begin
        int              rem[NREQ];
        logic [NREQ-1:0] acc_s;
        wrst = 1'b1; req_valid = '0; req_last = '0; req_data = '0; wfull = 1'b0;
        repeat (3) @(posedge wclk);
        #1 wrst = 1'b0;
        // Phases: 0 random, 1 all valid single-beat, 2 requester 3 overlong bursts, 3 random with resets
        for (int ph = 0; ph < 4; ph++) begin
            foreach (rem[i]) rem[i] = ph == 1 ? 1 : ph == 2 ? 20 : int'($urandom_range(1, 20));
            for (int c = 0; c < 1500; c++) begin
                @(negedge wclk);
                acc_s = req_ready;
                @(posedge wclk);
                #1;
                wrst  = (ph == 3) && ($urandom_range(99) == 0);
                wfull = (ph == 0 || ph == 3) && ($urandom_range(4) == 0);
                for (int i = 0; i < NREQ; i++) begin
                    if (acc_s[i]) rem[i]--;
                    if (rem[i] <= 0) rem[i] = ph == 1 ? 1 : ph == 2 ? 20 : int'($urandom_range(1, 20));
                    req_valid[i] = ph == 1 ? 1'b1 : ph == 2 ? (i == 3) : ($urandom_range(9) < 7);
                    req_last[i]  = (rem[i] == 1);
                    req_data[i*DSIZE +: DSIZE] = DSIZE'($urandom);
                end
            end
        end
        @(posedge wclk);
        #1;
        wrst = 1'b0; req_valid = '0; wfull = 1'b0;
        repeat (MAXB + 4) @(posedge wclk);
        @(negedge wclk);
        #2;
        chk("leftover_beats", bq.size(), 0);
`ifdef FIFO_WR_ARB_STATS_EN
        for (int i = 0; i < NREQ; i++) chk("beat_cnt", int'(beat_cnt[i*16 +: 16]), m_stat[i]);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
